// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Streams instruction words from a valid/ready source into instruction memory,
// starting at address 0. While a program is being loaded the processor is held
// in reset. A short hold window follows the last word, after which the
// processor is released. The loader then watches the processor's FSM state and
// raises done once the HALT state is seen.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   When defined, the in_last word is a checksum, not an instruction. It is
//   compared against the 16-bit modular sum of the words written. A match
//   releases the processor; a mismatch raises error.
//   When undefined, the in_last word is written like any other word.
//
// Parameters:
//   DATA_W      instruction word width
//   ADDR_W      instruction memory address width
//   HOLD_CYCLES cycles cpu_reset stays high after the last write (1..15)
//   HALT_STATE  processor FSM state code that means HALT
//
// Ports:
//   clk          system clock, rising edge
//   Reset        synchronous active-low reset
//   load_req     one-cycle pulse that starts a load
//   in_valid     in_data carries a valid word
//   in_ready     loader accepts a word this cycle (registered)
//   in_data      instruction word
//   in_last      final word of the program
//   cpu_state    processor current FSM state
//   mem_wr_en    instruction memory write enable (registered)
//   mem_addr     instruction memory write address (registered)
//   mem_wr_data  instruction memory write data (registered)
//   cpu_reset    active-high reset to the processor (registered)
//   word_count   words written by the current or last load
//   done         processor reached HALT_STATE
//   error        load failed (overflow or checksum mismatch)
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int         DATA_W      = 16,
  parameter int         ADDR_W      = 7,
  parameter int         HOLD_CYCLES = 3,
  parameter logic [3:0] HALT_STATE  = 4'd9
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [3:0]        cpu_state,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    HOLD   = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // One past the last memory address: a write request at this count has no
  // slot left in memory.
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      HOLD_INIT = 4'(HOLD_CYCLES);

  state_t      state;
  logic [3:0]  hold_cnt;
  logic        handshake;
  logic        at_capacity;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  assign handshake   = in_valid & in_ready;
  assign at_capacity = (word_count == MAX_WORDS);

  // Single registered FSM. Every output is a flop so the memory port and the
  // processor reset are glitch-free. mem_wr_en defaults low each cycle and is
  // only raised for the cycle directly after an accepted word.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state       <= IDLE;
      hold_cnt    <= 4'd0;
      in_ready    <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      cpu_reset   <= 1'b1;
      word_count  <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      mem_wr_en <= 1'b0;

      // A load request restarts from any state except LOAD itself, so a
      // stream that is already in flight cannot be torn in half.
      if (load_req && (state != LOAD)) begin
        state      <= LOAD;
        hold_cnt   <= 4'd0;
        in_ready   <= 1'b1;
        cpu_reset  <= 1'b1;
        word_count <= '0;
        done       <= 1'b0;
        error      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        checksum   <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
          end

          LOAD: begin
            if (handshake) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              // The last word is the expected sum; it is never written and
              // does not count, so a lone last word is a zero-length program.
              if (in_last) begin
                in_ready <= 1'b0;
                if (checksum == in_data) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_INIT;
                end else begin
                  state <= ERROR;
                  error <= 1'b1;
                end
              end else if (at_capacity) begin
                state    <= ERROR;
                error    <= 1'b1;
                in_ready <= 1'b0;
              end else begin
                mem_wr_en   <= 1'b1;
                mem_addr    <= word_count[ADDR_W-1:0];
                mem_wr_data <= in_data;
                word_count  <= word_count + (ADDR_W+1)'(1);
                checksum    <= checksum + in_data;
              end
`else
              // A full memory cannot take another word, even a last one, so
              // any word arriving at capacity is dropped and flagged.
              if (at_capacity) begin
                state    <= ERROR;
                error    <= 1'b1;
                in_ready <= 1'b0;
              end else begin
                mem_wr_en   <= 1'b1;
                mem_addr    <= word_count[ADDR_W-1:0];
                mem_wr_data <= in_data;
                word_count  <= word_count + (ADDR_W+1)'(1);
                if (in_last) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_INIT;
                  in_ready <= 1'b0;
                end
              end
`endif
            end
          end

          // The counter is loaded on the same edge that presents the last
          // write, and release happens on the edge where it reads 1. That
          // places the falling edge of cpu_reset exactly HOLD_CYCLES cycles
          // after the write cycle.
          HOLD: begin
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            if (hold_cnt <= 4'd1) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - 4'd1;
            end
          end

          RUN: begin
            cpu_reset <= 1'b0;
            if (cpu_state == HALT_STATE) begin
              state <= HALTED;
              done  <= 1'b1;
            end
          end

          // The processor stays out of reset so it remains parked in HALT.
          HALTED: begin
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end

          ERROR: begin
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            error     <= 1'b1;
          end

          default: begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. Random programs are streamed with
// random gaps. The expected memory image, word counts, error flag, hold window
// and halt behaviour are derived from a simple transaction-level model, and
// the writes seen on the memory port are collected and compared against it.
// Builds with or without PROGRAM_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int         DATA_W      = 16;
  localparam int         ADDR_W      = 7;
  localparam int         HOLD_CYCLES = 3;
  localparam logic [3:0] HALT_STATE  = 4'd9;
  localparam int         DEPTH       = 1 << ADDR_W;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk;
  logic              Reset;
  logic              load_req;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [3:0]        cpu_state;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              cpu_reset;
  logic [ADDR_W:0]   word_count;
  logic              done;
  logic              error;

  program_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .HOLD_CYCLES(HOLD_CYCLES), .HALT_STATE(HALT_STATE)
  ) dut (
    .clk(clk), .Reset(Reset), .load_req(load_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .cpu_state(cpu_state),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .cpu_reset(cpu_reset), .word_count(word_count),
    .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Stimulus program and the reference model state.
  logic [DATA_W-1:0] words[$];
  int                gaps[$];
  logic [DATA_W-1:0] expect_mem[$];
  int                exp_wc;

  // Everything that appears on the memory write port.
  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];

  // Mid-cycle sampling of the write port.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wr_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst in_ready",    in_ready,    0);
    checkOutput("rst mem_wr_en",   mem_wr_en,   0);
    checkOutput("rst mem_addr",    mem_addr,    0);
    checkOutput("rst mem_wr_data", mem_wr_data, 0);
    checkOutput("rst cpu_reset",   cpu_reset,   1);
    checkOutput("rst word_count",  word_count,  0);
    checkOutput("rst done",        done,        0);
    checkOutput("rst error",       error,       0);
  endtask

  task automatic doReset();
    Reset = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; cpu_state = 4'd0;
    step();
    step();
    checkResetValues();
    Reset = 1'b1;
    step();
    checkOutput("idle cpu_reset", cpu_reset, 1);
    checkOutput("idle in_ready", in_ready, 0);
  endtask

  // Random program of n words with gaps of up to maxgap idle cycles.
  task automatic buildProgram(input int n, input int maxgap);
    words.delete();
    gaps.delete();
    for (int i = 0; i < n; i++) begin
      words.push_back(16'($urandom));
      gaps.push_back($urandom_range(0, maxgap));
    end
  endtask

  // In checksum builds the final word becomes the sum of all the others.
  task automatic sealProgram();
    logic [DATA_W-1:0] sum;
    if (CSUM) begin
      sum = '0;
      for (int i = 0; i < words.size() - 1; i++) sum = sum + words[i];
      words[words.size()-1] = sum;
    end
  endtask

  task automatic pulseLoad();
    load_req = 1'b1;
    log_addr.delete();
    log_data.delete();
    expect_mem.delete();
    exp_wc = 0;
    step();
    load_req = 1'b0;
    checkOutput("load in_ready",   in_ready,   1);
    checkOutput("load cpu_reset",  cpu_reset,  1);
    checkOutput("load word_count", word_count, 0);
    checkOutput("load done",       done,       0);
    checkOutput("load error",      error,      0);
  endtask

  // Stream words[0..n-1]; with_last tags the final one with in_last.
  task automatic applyStimulus(input int n, input bit with_last);
    bit                is_last, overflow, written, final_word, exp_err;
    logic [DATA_W-1:0] sum;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        load_req = 1'($urandom_range(0, 1));
        step();
        load_req = 1'b0;
        checkOutput("gap mem_wr_en", mem_wr_en, 0);
        checkOutput("gap word_count", word_count, exp_wc);
      end
      checkOutput("pre-word in_ready", in_ready, 1);
      is_last  = with_last && (i == n - 1);
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = is_last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;

      overflow = (exp_wc == DEPTH) && !(CSUM && is_last);
      written  = !overflow && !(CSUM && is_last);
      sum = '0;
      foreach (expect_mem[k]) sum = sum + expect_mem[k];
      exp_err    = overflow || (CSUM && is_last && (sum != words[i]));
      final_word = is_last || overflow;

      if (written) begin
        checkOutput("word mem_wr_en", mem_wr_en, 1);
        checkOutput("word mem_addr", mem_addr, exp_wc);
        checkOutput("word mem_wr_data", mem_wr_data, words[i]);
        expect_mem.push_back(words[i]);
        exp_wc++;
      end else begin
        checkOutput("drop mem_wr_en", mem_wr_en, 0);
      end
      checkOutput("word word_count", word_count, exp_wc);
      checkOutput("word in_ready", in_ready, final_word ? 0 : 1);
      if (final_word) begin
        checkOutput("final error", error, exp_err);
        checkOutput("final cpu_reset", cpu_reset, 1);
      end
    end
  endtask

  // Compare the collected write log with the model's memory image.
  task automatic checkLog();
    checkOutput("log write count", log_addr.size(), expect_mem.size());
    for (int i = 0; i < log_addr.size() && i < expect_mem.size(); i++) begin
      checkOutput("log addr", log_addr[i], i);
      checkOutput("log data", log_data[i], expect_mem[i]);
    end
  endtask

  // Called straight after the in_last handshake; counts cycles to release.
  task automatic waitRun();
    int n = 0;
    while (cpu_reset !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    if (CSUM) checkOutput("release within bound", (n < 20), 1);
    else      checkOutput("hold cycles", n, HOLD_CYCLES);
    checkOutput("run error", error, 0);
  endtask

  task automatic runToHalt();
    int busy = $urandom_range(1, 4);
    for (int k = 0; k < busy; k++) begin
      cpu_state = 4'($urandom_range(0, 8));
      step();
      checkOutput("run done", done, 0);
      checkOutput("run cpu_reset", cpu_reset, 0);
    end
    cpu_state = HALT_STATE;
    step();
    checkOutput("halt done", done, 1);
    checkOutput("halt cpu_reset", cpu_reset, 0);
    cpu_state = 4'($urandom_range(0, 8));
    step();
    checkOutput("parked done", done, 1);
    checkOutput("parked cpu_reset", cpu_reset, 0);
    cpu_state = 4'd0;
  endtask

  initial begin
    int n;
    doReset();

    // Basic back-to-back load of 5 words, then run to HALT.
    buildProgram(5, 0);
    sealProgram();
    pulseLoad();
    applyStimulus(5, 1);
    checkOutput("basic word_count", word_count, CSUM ? 4 : 5);
    waitRun();
    checkLog();
    runToHalt();

    // Random gapped program from HALTED, then reload while in RUN.
    n = $urandom_range(6, 20);
    buildProgram(n, 2);
    sealProgram();
    pulseLoad();
    applyStimulus(n, 1);
    waitRun();
    checkLog();
    pulseLoad();
    n = $urandom_range(2, 12);
    buildProgram(n, 3);
    sealProgram();
    applyStimulus(n, 1);
    waitRun();
    checkLog();
    runToHalt();

    // Backpressure: in_valid pattern 1,0,0,1,1 over 3 words.
    buildProgram(3, 0);
    gaps[1] = 2;
    sealProgram();
    pulseLoad();
    applyStimulus(3, 1);
    waitRun();
    checkLog();

    // Overflow: 129 words without in_last.
    buildProgram(DEPTH + 1, 0);
    pulseLoad();
    applyStimulus(DEPTH + 1, 0);
    checkOutput("ovf error", error, 1);
    checkOutput("ovf in_ready", in_ready, 0);
    checkOutput("ovf cpu_reset", cpu_reset, 1);
    checkOutput("ovf word_count", word_count, DEPTH);
    checkLog();
    step();
    checkOutput("ovf error sticky", error, 1);

    // Mid-load reset after two writes, then a fresh load still works.
    buildProgram(2, 0);
    pulseLoad();
    applyStimulus(2, 0);
    Reset = 1'b0;
    step();
    checkResetValues();
    Reset = 1'b1;
    step();
    buildProgram(4, 1);
    sealProgram();
    pulseLoad();
    applyStimulus(4, 1);
    waitRun();
    checkLog();
    runToHalt();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Directed checksums: 1+2+3 == 6 releases, 7 is rejected.
    words.delete(); gaps.delete();
    words = '{16'h0001, 16'h0002, 16'h0003, 16'h0006};
    gaps  = '{0, 0, 0, 0};
    pulseLoad();
    applyStimulus(4, 1);
    waitRun();
    checkLog();
    words[3] = 16'h0007;
    pulseLoad();
    applyStimulus(4, 1);
    checkOutput("csum bad error", error, 1);
    checkLog();
    // Zero-length program: a lone last word of 0.
    words = '{16'h0000};
    gaps  = '{0};
    pulseLoad();
    applyStimulus(1, 1);
    waitRun();
    checkOutput("zero-length word_count", word_count, 0);
    checkLog();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream companion to the processor. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory starting at address 0. While loading, it holds the processor in reset, then releases it. It watches the processor's FSM state and flags completion when the HALT state is reached. The test harness and board top use it so programs can be swapped without rebuilding the memory image.

## Interface
- `DATA_W`, 16, instruction word width
- `ADDR_W`, 7, instruction memory address width (matches PC width)
- `HOLD_CYCLES`, 3, cycles the processor reset stays asserted after the last write (1..15)
- `HALT_STATE`, 9, processor FSM state code that means HALT

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `Reset`  in  1  synchronous, active-low reset (0 = reset)
- `load_req`  in  1  one-cycle pulse that starts a load
- `in_valid`  in  1  word on `in_data` is valid
- `in_ready`  out  1  loader can accept a word
- `in_data`  in  DATA_W  instruction word
- `in_last`  in  1  marks the final word of the program
- `cpu_state`  in  4  processor current FSM state
- `mem_wr_en`  out  1  instruction memory write enable
- `mem_addr`  out  ADDR_W  instruction memory write address
- `mem_wr_data`  out  DATA_W  instruction memory write data
- `cpu_reset`  out  1  active-high reset to the processor
- `word_count`  out  ADDR_W+1  number of words written by the current or last load
- `done`  out  1  processor reached `HALT_STATE`
- `error`  out  1  load failed (overflow, or checksum mismatch when enabled)

## Operation
States and encoding: IDLE=0, LOAD=1, HOLD=2, RUN=3, HALTED=4, ERROR=5.
- **IDLE:** `cpu_reset`=1. `load_req` goes to LOAD and clears `word_count`, `done` and `error`.
- **LOAD:** `in_ready`=1. A handshake (`in_valid & in_ready`) writes `in_data` at address `word_count`, then increments `word_count`.
  - A handshake with `in_last`=1 goes to HOLD and loads the hold counter with `HOLD_CYCLES`.
  - A handshake at `word_count`=2^ADDR_W without `in_last` goes to ERROR. That word is not written.
- **HOLD:** `cpu_reset`=1. The counter decrements each cycle. When it reaches 1, the FSM goes to RUN.
- **RUN:** `cpu_reset`=0. When `cpu_state`==`HALT_STATE`, the FSM goes to HALTED.
- **HALTED:** `done`=1 and `cpu_reset`=0. The processor is left parked in HALT.
- **ERROR:** `error`=1 and `cpu_reset`=1.
- **`load_req` in any state except LOAD:** the FSM enters LOAD next cycle, `cpu_reset` goes to 1, and flags clear. `load_req` during LOAD is ignored.
- **Back-to-back words:** `in_valid` held high with `in_ready` high is accepted every cycle.
- **Reset mid-load:** the FSM returns to IDLE. Memory contents already written stay as they are.

## Timing
- **Reset values:** state IDLE, `in_ready`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `cpu_reset`=1, `word_count`=0, `done`=0, `error`=0.
- **Write port:** `mem_wr_en`, `mem_addr` and `mem_wr_data` are registered. The write appears exactly 1 cycle after its handshake cycle.
- **`in_ready`:** registered. It goes high the cycle after `load_req` and low the cycle after the `in_last` handshake or the overflow.
- **Hold window:** `cpu_reset` falls exactly `HOLD_CYCLES` cycles after the cycle in which the last write is presented on the memory port.
- **`done`:** rises 1 cycle after `cpu_state`==`HALT_STATE` is sampled in RUN.

## Configuration
- **`PROGRAM_LOADER_CHECKSUM_EN` defined:**
  - The `in_last` word is a checksum and is not written to memory. It does not count in `word_count`.
  - A 16-bit modular sum of all written words is compared against it.
  - Match goes to HOLD; mismatch goes to ERROR.
  - A stream consisting only of an `in_last` word is a zero-length program with expected checksum 0.
- **Not defined:** the `in_last` word is an ordinary instruction and is written. There is no checksum logic.

## Test plan
- **Basic load and run (macro off):** reset, `load_req`, stream 5 words with `in_last` on the 5th. Expect:
  - writes at addresses 0..4, one per cycle;
  - `word_count`=5;
  - `cpu_reset` falls 3 cycles after the write to address 4;
  - `cpu_state` driven to 9 gives `done`=1 the next cycle.
- **Backpressure gaps:** `in_valid` toggled 1,0,0,1,1 over 3 words. Expect exactly 3 writes at addresses 0..2 and no duplicated address.
- **Overflow:** stream 129 words without `in_last`. Expect 128 writes, `error`=1, `in_ready`=0, and `cpu_reset` still 1.
- **Checksum (macro on):** words 0x0001, 0x0002, 0x0003, then `in_last` 0x0006. Expect 3 writes and a transition to RUN. Repeat with `in_last` 0x0007 and expect ERROR with `error`=1.
- **Reload from RUN:** `load_req` while in RUN. Expect `cpu_reset`=1 the next cycle, state LOAD, and `word_count`=0.
- **Mid-load reset:** `Reset`=0 after 2 writes. Expect the reset values next cycle and `load_req` still accepted afterwards.
